// File: rtl/cycle_seq_pkg.sv
// Shared definitions for the cycle sequencer: phase encodings and default
// multiply/divide timeout.
package cycle_seq_pkg;

   localparam int PHASE_W        = 3;
   localparam int MD_TIMEOUT_DEF = 64;

   typedef enum logic [PHASE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MDWAIT = 3'd4,
      ST_MEM    = 3'd5,
      ST_WB     = 3'd6
   } state_e;

endpackage

// File: rtl/seq_wait_counter.sv
// Clearable up-counter that saturates at TC_VAL and flags the terminal count;
// bounds the time spent waiting on the multiply/divide unit.
module seq_wait_counter #(
   parameter int TC_VAL = 63,
   parameter int W      = (TC_VAL > 0) ? $clog2(TC_VAL + 1) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam logic [W-1:0] TC_L = W'(TC_VAL);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: clear wins, otherwise step until the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (inc && (cnt_q != TC_L)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == TC_L);

endmodule

// File: rtl/cycle_sequencer.sv
// Phase sequencer for the single-issue core: one clock, per-stage enables,
// extra phases for memory and multiply/divide, bounded multdiv wait.
module cycle_sequencer
   import cycle_seq_pkg::*;
#(
   parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
   parameter int CNT_W      = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   input  logic               is_lw,
   input  logic               is_sw,
   input  logic               is_md,
   input  logic               rf_wr,
   input  logic               md_ready,
   output logic               pc_en,
   output logic               imem_en,
   output logic               rf_rd_en,
   output logic               md_start,
   output logic               dmem_en,
   output logic               dmem_we,
   output logic               rf_we,
   output logic [PHASE_W-1:0] phase,
   output logic               busy,
   output logic               md_err,
   output logic [CNT_W-1:0]   instr_count
);

   state_e             state_q, state_d;
   logic               md_err_q, md_err_d;
   logic               to_flag_q, to_flag_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               wc_clr_s;
   logic               wc_inc_s;
   logic               wc_tc_s;

   seq_wait_counter #(
      .TC_VAL (MD_TIMEOUT - 1)
   ) u_wait (
      .clock (clock),
      .reset (reset),
      .clr   (wc_clr_s),
      .inc   (wc_inc_s),
      .tc    (wc_tc_s)
   );

   // next-state, sticky error, timeout flag and retire counter
   always_comb begin
      state_d   = state_q;
      md_err_d  = md_err_q;
      to_flag_d = to_flag_q;
      count_d   = count_q;
      wc_clr_s  = 1'b0;
      wc_inc_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
            else     state_d = ST_IDLE;
         end
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (is_md) begin
               state_d  = ST_MDWAIT;
               wc_clr_s = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_WB;
            end
         end
         // a ready arriving on the terminal cycle still counts as normal completion
         ST_MDWAIT: begin
            if (md_ready) begin
               state_d = ST_WB;
            end else if (wc_tc_s) begin
               state_d   = ST_WB;
               to_flag_d = 1'b1;
               md_err_d  = 1'b1;
            end else begin
               wc_inc_s = 1'b1;
            end
         end
         ST_MEM: state_d = ST_WB;
         ST_WB: begin
            count_d   = count_q + CNT_W'(1);
            to_flag_d = 1'b0;
            if (run) state_d = ST_FETCH;
            else     state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and bookkeeping registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         md_err_q  <= 1'b0;
         to_flag_q <= 1'b0;
         count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q   <= state_d;
         md_err_q  <= md_err_d;
         to_flag_q <= to_flag_d;
         count_q   <= count_d;
      end
   end

   // Moore enable decode from the state register
   always_comb begin
      pc_en    = 1'b0;
      imem_en  = 1'b0;
      rf_rd_en = 1'b0;
      md_start = 1'b0;
      dmem_en  = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      case (state_q)
         ST_FETCH:  imem_en  = 1'b1;
         ST_DECODE: rf_rd_en = 1'b1;
         ST_EXEC:   md_start = is_md;
         ST_MEM: begin
            dmem_en = 1'b1;
            dmem_we = is_sw;
         end
         ST_WB: begin
            pc_en = 1'b1;
            rf_we = rf_wr & ~to_flag_q;
         end
         default: pc_en = 1'b0;
      endcase
   end

   assign phase       = state_q;
   assign busy        = (state_q != ST_IDLE);
   assign md_err      = md_err_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: instance A (MD_TIMEOUT=16, CNT_W=4) covers
// fetch/decode/memory/multdiv/run-stop/wrap; instance B (MD_TIMEOUT=4) covers timeout.
module tb_cycle_sequencer;

   logic clock = 1'b0;
   logic reset;
   logic run_a, run_b;
   logic is_lw, is_sw, is_md, rf_wr, md_ready;

   logic       pc_en_a, imem_en_a, rf_rd_en_a, md_start_a, dmem_en_a, dmem_we_a, rf_we_a;
   logic [2:0] phase_a;
   logic       busy_a, md_err_a;
   logic [3:0] count_a;

   logic        pc_en_b, imem_en_b, rf_rd_en_b, md_start_b, dmem_en_b, dmem_we_b, rf_we_b;
   logic [2:0]  phase_b;
   logic        busy_b, md_err_b;
   logic [31:0] count_b;

   logic [6:0] en_a, en_b;
   int n_checks = 0;
   int n_fail   = 0;

   // enable vectors: {pc_en, imem_en, rf_rd_en, md_start, dmem_en, dmem_we, rf_we}
   localparam logic [6:0] E_NONE = 7'b0000000;
   localparam logic [6:0] E_F    = 7'b0100000;
   localparam logic [6:0] E_D    = 7'b0010000;
   localparam logic [6:0] E_MDS  = 7'b0001000;
   localparam logic [6:0] E_LW   = 7'b0000100;
   localparam logic [6:0] E_SW   = 7'b0000110;
   localparam logic [6:0] E_WBW  = 7'b1000001;
   localparam logic [6:0] E_WB0  = 7'b1000000;

   assign en_a = {pc_en_a, imem_en_a, rf_rd_en_a, md_start_a, dmem_en_a, dmem_we_a, rf_we_a};
   assign en_b = {pc_en_b, imem_en_b, rf_rd_en_b, md_start_b, dmem_en_b, dmem_we_b, rf_we_b};

   always #5 clock = ~clock;

   cycle_sequencer #(.MD_TIMEOUT(16), .CNT_W(4)) dut_a (
      .clock(clock), .reset(reset), .run(run_a),
      .is_lw(is_lw), .is_sw(is_sw), .is_md(is_md), .rf_wr(rf_wr), .md_ready(md_ready),
      .pc_en(pc_en_a), .imem_en(imem_en_a), .rf_rd_en(rf_rd_en_a), .md_start(md_start_a),
      .dmem_en(dmem_en_a), .dmem_we(dmem_we_a), .rf_we(rf_we_a),
      .phase(phase_a), .busy(busy_a), .md_err(md_err_a), .instr_count(count_a)
   );

   cycle_sequencer #(.MD_TIMEOUT(4), .CNT_W(32)) dut_b (
      .clock(clock), .reset(reset), .run(run_b),
      .is_lw(is_lw), .is_sw(is_sw), .is_md(is_md), .rf_wr(rf_wr), .md_ready(md_ready),
      .pc_en(pc_en_b), .imem_en(imem_en_b), .rf_rd_en(rf_rd_en_b), .md_start(md_start_b),
      .dmem_en(dmem_en_b), .dmem_we(dmem_we_b), .rf_we(rf_we_b),
      .phase(phase_b), .busy(busy_b), .md_err(md_err_b), .instr_count(count_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cyc_a(input string tag, input logic [2:0] ph, input logic [6:0] en);
      chk({tag, ".phase_a"}, 32'(phase_a), 32'(ph));
      chk({tag, ".en_a"}, 32'(en_a), 32'(en));
   endtask

   task automatic cyc_b(input string tag, input logic [2:0] ph, input logic [6:0] en);
      chk({tag, ".phase_b"}, 32'(phase_b), 32'(ph));
      chk({tag, ".en_b"}, 32'(en_b), 32'(en));
   endtask

   initial begin
      reset = 1'b0; run_a = 1'b1; run_b = 1'b0;
      is_lw = 1'b0; is_sw = 1'b0; is_md = 1'b0; rf_wr = 1'b1; md_ready = 1'b0;

      // reset held with run high
      #12;
      cyc_a("rst", 3'd0, E_NONE);
      chk("rst.busy", 32'(busy_a), 32'd0);
      chk("rst.md_err", 32'(md_err_a), 32'd0);
      chk("rst.count", 32'(count_a), 32'd0);
      reset = 1'b1;

      // ALU instruction: F, D, E, WB
      step(); cyc_a("alu.F", 3'd1, E_F);
      chk("alu.busy", 32'(busy_a), 32'd1);
      step(); cyc_a("alu.D", 3'd2, E_D);
      step(); cyc_a("alu.E", 3'd3, E_NONE);
      step(); cyc_a("alu.WB", 3'd6, E_WBW);
      chk("alu.cnt_wb", 32'(count_a), 32'd0);
      step(); cyc_a("alu.F2", 3'd1, E_F);
      chk("alu.count", 32'(count_a), 32'd1);

      // three back-to-back loads
      is_lw = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            step(); cyc_a("lw.F", 3'd1, E_F);
         end
         step(); cyc_a("lw.D", 3'd2, E_D);
         step(); cyc_a("lw.E", 3'd3, E_NONE);
         step(); cyc_a("lw.MEM", 3'd5, E_LW);
         step(); cyc_a("lw.WB", 3'd6, E_WBW);
      end
      is_lw = 1'b0;
      step(); cyc_a("lw.next", 3'd1, E_F);
      chk("lw.count", 32'(count_a), 32'd4);

      // store without register write
      is_sw = 1'b1; rf_wr = 1'b0;
      step(); cyc_a("sw.D", 3'd2, E_D);
      step(); cyc_a("sw.E", 3'd3, E_NONE);
      step(); cyc_a("sw.MEM", 3'd5, E_SW);
      step(); cyc_a("sw.WB", 3'd6, E_WB0);
      is_sw = 1'b0;
      step(); chk("sw.count", 32'(count_a), 32'd5);

      // multdiv: ready in EXEC ignored, ready on 10th MDWAIT cycle
      is_md = 1'b1; rf_wr = 1'b1;
      step(); cyc_a("md.D", 3'd2, E_D);
      step(); cyc_a("md.E", 3'd3, E_MDS);
      md_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step(); md_ready = 1'b0;
         cyc_a("md.WAIT", 3'd4, E_NONE);
         if (i == 10) md_ready = 1'b1;
      end
      step(); md_ready = 1'b0;
      cyc_a("md.WB", 3'd6, E_WBW);
      chk("md.err", 32'(md_err_a), 32'd0);
      is_md = 1'b0;
      step(); chk("md.count", 32'(count_a), 32'd6);

      // run dropped during DECODE
      step(); cyc_a("stop.D", 3'd2, E_D);
      run_a = 1'b0;
      step(); cyc_a("stop.E", 3'd3, E_NONE);
      step(); cyc_a("stop.WB", 3'd6, E_WBW);
      step(); cyc_a("stop.IDLE", 3'd0, E_NONE);
      chk("stop.busy", 32'(busy_a), 32'd0);
      chk("stop.count", 32'(count_a), 32'd7);
      step(); chk("stop.hold", 32'(phase_a), 32'd0);

      // 4-bit counter wraps after 9 more retires
      run_a = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         step(); step(); step(); step();
      end
      cyc_a("wrap.F", 3'd1, E_F);
      chk("wrap.15", 32'(count_a), 32'd15);
      run_a = 1'b0;
      step(); step(); step(); step();
      chk("wrap.idle", 32'(phase_a), 32'd0);
      chk("wrap.0", 32'(count_a), 32'd0);

      // instance B: ready on the 4th (terminal) MDWAIT cycle
      is_md = 1'b1; rf_wr = 1'b1; run_b = 1'b1;
      step(); cyc_b("mdr.F", 3'd1, E_F);
      step(); cyc_b("mdr.D", 3'd2, E_D);
      step(); cyc_b("mdr.E", 3'd3, E_MDS);
      for (int i = 1; i <= 4; i++) begin
         step(); cyc_b("mdr.WAIT", 3'd4, E_NONE);
         if (i == 4) md_ready = 1'b1;
      end
      step(); md_ready = 1'b0;
      cyc_b("mdr.WB", 3'd6, E_WBW);
      chk("mdr.err", 32'(md_err_b), 32'd0);

      // instance B: timeout after exactly 4 MDWAIT cycles
      step(); cyc_b("to.F", 3'd1, E_F);
      step(); cyc_b("to.D", 3'd2, E_D);
      step(); cyc_b("to.E", 3'd3, E_MDS);
      for (int i = 1; i <= 4; i++) begin
         step(); cyc_b("to.WAIT", 3'd4, E_NONE);
      end
      step(); cyc_b("to.WB", 3'd6, E_WB0);
      chk("to.err", 32'(md_err_b), 32'd1);
      is_md = 1'b0;
      step(); cyc_b("to.F2", 3'd1, E_F);
      chk("to.count", 32'(count_b), 32'd2);
      step(); step();
      step(); cyc_b("to.alu_WB", 3'd6, E_WBW);
      chk("to.sticky", 32'(md_err_b), 32'd1);

      // asynchronous reset mid-instruction
      step(); step();
      cyc_b("ar.pre", 3'd2, E_D);
      reset = 1'b0;
      #1;
      cyc_b("ar", 3'd0, E_NONE);
      chk("ar.busy", 32'(busy_b), 32'd0);
      chk("ar.err", 32'(md_err_b), 32'd0);
      chk("ar.count", 32'(count_b), 32'd0);
      #4;
      reset = 1'b1;
      step(); cyc_b("ar.restart", 3'd1, E_F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Multi-phase instruction sequencer for the single-issue MIPS-style processor core. It replaces the free-running divided clocks with one clock plus per-stage enables, so PC, imem, regfile, multdiv and dmem advance only in their own phase. It inserts the extra phases that memory and multiply/divide instructions need, and bounds the multdiv wait with a timeout. It sits beside the skeleton datapath and drives its enable inputs.

## Interface
- MD_TIMEOUT, 64: max cycles spent in MDWAIT before forced completion (≥1)
- CNT_W, 32: width of retired-instruction counter
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- run  in  1  level; high = keep issuing instructions, low = stop at next instruction boundary
- is_lw  in  1  current instruction is a load; valid from DECODE onward
- is_sw  in  1  current instruction is a store; valid from DECODE onward
- is_md  in  1  current instruction is mult/div; valid from DECODE onward
- rf_wr  in  1  current instruction writes a register; valid from DECODE onward
- md_ready  in  1  multdiv result valid (single-cycle pulse or level)
- pc_en  out  1  PC register load enable
- imem_en  out  1  instruction memory read/latch enable
- rf_rd_en  out  1  regfile read-port latch enable
- md_start  out  1  one-cycle multdiv start pulse
- dmem_en  out  1  data memory access enable
- dmem_we  out  1  data memory write enable
- rf_we  out  1  regfile write enable
- phase  out  3  current state encoding
- busy  out  1  high whenever state ≠ IDLE
- md_err  out  1  sticky: a multdiv timeout has occurred
- instr_count  out  CNT_W  retired-instruction count

## Operation
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MDWAIT=4, MEM=5, WB=6; encodings 7 → IDLE.
- IDLE: run=1 → FETCH; else stay.
- FETCH: imem_en=1 → DECODE.
- DECODE: rf_rd_en=1 → EXEC.
- EXEC: priority is_md > (is_lw|is_sw) > other. is_md: md_start=1 → MDWAIT, wait counter cleared. Load/store → MEM. Otherwise → WB.
- MDWAIT: md_ready=1 → WB. Else the counter increments. When the counter reaches MD_TIMEOUT−1 without ready → WB with timeout flag set and md_err set. md_ready wins over a simultaneous timeout. md_ready seen in EXEC is ignored.
- MEM: dmem_en=1, dmem_we=is_sw → WB.
- WB: pc_en=1; rf_we=rf_wr & ~timeout_flag; instr_count+=1, wrapping modulo 2^CNT_W. → FETCH if run, else IDLE. timeout_flag clears on leaving WB.
- run deasserted mid-instruction does not abort: the instruction completes through WB, then goes to IDLE.
- All enables are Moore decodes of the state register. dmem_we and rf_we also gate on decoded inputs. Every enable is 0 outside its state.
- md_err is cleared only by reset.

## Timing
- Reset (asynchronous assert) values: state IDLE, all enables 0, phase=0, busy=0, md_err=0, instr_count=0, wait counter 0, timeout_flag 0.
- Release of reset is synchronous to clock. The first FETCH is one cycle after run is seen high in IDLE.
- Cycles per instruction: ALU/branch 4 (F,D,E,WB); lw/sw 5; mult/div 4+N, where N = cycles in MDWAIT (1..MD_TIMEOUT).
- Back-to-back with run=1: FETCH of instruction k+1 is the cycle after WB of instruction k, with no IDLE gap.
- instr_count updates on the clock edge ending WB and is visible the following cycle.
- Reset asserted mid-instruction: outputs drop to reset values without waiting for a clock edge. No partial WB occurs.

## Structure
- Shared package cycle_seq_pkg: state encodings (localparams/typedef), phase width, default MD_TIMEOUT.
- One sub-module, seq_wait_counter: a clearable counter with a terminal-count flag, used for the MDWAIT timeout. Everything else stays in one FSM module.

## Test plan
- Reset held low with run=1 → all outputs 0, phase=0. Release reset → phase sequence 1,2,3,6,1… with imem_en,rf_rd_en,pc_en each high exactly one cycle; instr_count=1 after first WB.
- Continuous is_lw=1 for 3 instructions → 15 cycles. dmem_en high in each phase-5 cycle with dmem_we=0. instr_count=3.
- is_sw=1, rf_wr=0 → dmem_we=1 in MEM, rf_we=0 in WB.
- is_md=1, md_ready pulsed 10 cycles after md_start → md_start high one cycle, 10 MDWAIT cycles, rf_we=rf_wr in WB, md_err=0.
- MD_TIMEOUT=4, md_ready never asserted → WB reached after exactly 4 MDWAIT cycles, rf_we=0, md_err=1 and sticky. md_ready on the 4th cycle instead → normal completion, md_err=0.
- run dropped during DECODE → instruction completes through WB, then phase=0, busy=0. With CNT_W=4 and count preset to 15, one more retire → count wraps to 0.
